accelerator: RTL and testbench
==============================

Name: accelerator

Overview:
- Compute core that sits directly downstream of the command/BRAM wrapper. It consumes the wrapper's 1024-bit core data word and returns a 1024-bit result with a one-cycle done pulse.
- Operation: 512-bit multi-precision addition, done one limb per cycle with a registered carry chain. This is the first arithmetic primitive of the crypto datapath.
- Operand packing: din[1023:512] = A, din[511:0] = B.
- Result packing: dout = {511'b0, carry_out, (A+B) mod 2^512}.

Parameters:
LIMB_W, 64, limb width in bits; must divide 512 (legal: 8, 16, 32, 64, 128, 256, 512)
N_LIMBS, 512/LIMB_W, derived localparam; number of limb iterations

Ports:
clk  input  1  system clock; all state updates on rising edge
resetn  input  1  reset, asynchronous and active-low
start  input  1  single-cycle request; samples din
din  input  1024  operands {A[511:0], B[511:0]}
dout  output  1024  result {511'b0, carry, sum[511:0]}; registered, held until the next completion
done  output  1  one-cycle pulse; dout is valid in the same cycle
busy  output  1  high while an operation is in flight (debug/LED use; may be left unconnected)

Behaviour:
- Reset (resetn=0, asynchronous) forces the following, at any time including mid-operation:
  - state=IDLE, done=0, busy=0, dout=0
  - limb counter=0, carry=0, operand and sum shift registers=0
  - an aborted operation produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: capture A and B into shift registers, carry<=0, cnt<=0, state<=RUN.
  - start=0: hold.
- RUN, at each edge Ek for k=1..N_LIMBS:
  - {c, s} = A_reg[LIMB_W-1:0] + B_reg[LIMB_W-1:0] + carry, computed at LIMB_W+1 bits.
  - carry<=c.
  - Shift A_reg and B_reg right by LIMB_W.
  - Shift s into the top of sum_reg (sum_reg <= {s, sum_reg[511:LIMB_W]}).
  - cnt<=cnt+1.
- Completion, at edge E_N_LIMBS (the last limb):
  - dout<={511'b0, c, final sum}.
  - done<=1.
  - state<=DONE.
- DONE (exactly one cycle):
  - done<=0 at the next edge; state<=IDLE.
  - A start seen in DONE is accepted exactly as in IDLE: transition directly to RUN; done still drops.
- Latency: done is high during the cycle following E_N_LIMBS, i.e. N_LIMBS cycles after the start-sampling edge (8 for LIMB_W=64).
- Back-to-back operations: the minimum start-to-start interval is N_LIMBS+1 cycles.
- busy: high in RUN only; low in IDLE and DONE.
- start while RUN: ignored. No queueing, no effect on the operation in flight, no extra done pulse.
- din only matters at the sampling edge. Later changes to din do not affect the operation in progress.
- dout changes only at a completion edge or on reset. It is not cleared by start.
- Upstream compatibility:
  - The wrapper drives start from a register for one cycle, then polls done in its wait state.
  - done must never be asserted without a preceding accepted start.
- Arithmetic:
  - Unsigned throughout.
  - Carry propagates across all limbs. The final carry out of bit 511 lands in dout[512].
  - dout[1023:513] is always 0.
- Counter: width $clog2(N_LIMBS)+1. It must not wrap within an operation. For LIMB_W=512, N_LIMBS=1 and the counter still terminates after one RUN edge.

Test Plan:
1. Reset then A=1, B=1, start pulse -> done after exactly 8 cycles (LIMB_W=64); dout=2; dout[1023:513]=0; busy high for 8 cycles.
2. Inter-limb carry: A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> dout=2^64 (bit 64 set, all else 0).
3. Full ripple: A=2^512-1, B=1 -> dout[511:0]=0, dout[512]=1. Then A=2^512-1, B=2^512-1 -> dout[511:0]=2^512-2, dout[512]=1.
4. start re-pulsed at cycle 3 of RUN with a different din -> single done at cycle 8 carrying the original result. A start in the DONE cycle -> second result 8 cycles later.
5. resetn low at cycle 4 of RUN -> done, busy, dout immediately 0; no done afterwards. A fresh start after release gives the correct result.
6. Parameter sweep LIMB_W=32 and 512 with random operands versus a reference A+B -> latency 16 and 1 respectively; exact 513-bit match over 1000 vectors.

Source files
------------

// File: rtl/accelerator.sv
// accelerator: 512-bit multi-precision adder. It computes one limb per cycle
// and carries between limbs through a register.
//
// Operands arrive packed as din = {A[511:0], B[511:0]} and are sampled on an
// accepted start. After N_LIMBS RUN cycles the block raises done for one
// cycle. In that same cycle dout = {511'b0, carry_out, (A+B) mod 2^512}.
// dout keeps that value until the next completion or until reset.
//
// Ports
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   start   one-cycle request; accepted in IDLE or DONE, ignored in RUN
//   din     {A, B} operands, only sampled on an accepted start
//   dout    registered result {511'b0, carry, sum}
//   done    one-cycle completion pulse, aligned with dout
//   busy    high while an operation is in RUN
module accelerator #(
    parameter int LIMB_W = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [1023:0] din,
    output logic [1023:0] dout,
    output logic          done,
    output logic          busy
);

    localparam int N_LIMBS = 512 / LIMB_W;
    // One extra bit so the counter reaches N_LIMBS without wrapping (also for N_LIMBS=1).
    localparam int CNT_W   = $clog2(N_LIMBS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [511:0]       a_reg, b_reg, sum_reg;
    logic [511:0]       a_shift, b_shift, sum_shift;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [LIMB_W:0]    limb_sum;
    logic               last_limb;
    logic               accept;

    // Add the current low limbs plus the carry, at LIMB_W+1 bits.
    assign limb_sum  = {1'b0, a_reg[LIMB_W-1:0]} + {1'b0, b_reg[LIMB_W-1:0]}
                     + {{LIMB_W{1'b0}}, carry};

    // The operands shift toward the LSB. Each new sum limb enters the sum
    // register at the top, so after N_LIMBS steps the sum is fully aligned.
    // These expressions also hold for LIMB_W=512, where the shifts clear everything.
    assign a_shift   = a_reg >> LIMB_W;
    assign b_shift   = b_reg >> LIMB_W;
    assign sum_shift = 512'({limb_sum[LIMB_W-1:0], sum_reg} >> LIMB_W);

    assign last_limb = (cnt == CNT_W'(N_LIMBS - 1));
    // The DONE cycle accepts start in the same way IDLE does.
    assign accept    = start && (state != RUN);
    assign busy      = (state == RUN);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_limb) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            done    <= 1'b0;
            dout    <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            state <= state_d;
            done  <= (state == RUN) && last_limb;
            if (accept) begin
                a_reg <= din[1023:512];
                b_reg <= din[511:0];
                carry <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_reg   <= a_shift;
                b_reg   <= b_shift;
                sum_reg <= sum_shift;
                carry   <= limb_sum[LIMB_W];
                cnt     <= cnt + 1'b1;
                if (last_limb)
                    dout <= {511'b0, limb_sum[LIMB_W], sum_shift};
            end
        end
    end

endmodule

// File: tb/tb_accelerator.sv
// Testbench for accelerator. The main instance uses LIMB_W=64 and runs
// directed vectors plus multi-cycle corner cases. Two more instances, with
// LIMB_W=32 and LIMB_W=512, share one random stimulus stream. Expected
// results go into per-instance queues at issue time and are checked when
// done is seen.
module tb_accelerator;

    logic          clk;
    logic          resetn;
    logic          start, start_s;
    logic [1023:0] din, din_s;
    logic [1023:0] dout, dout32, dout512;
    logic          done, done32, done512;
    logic          busy, busy32, busy512;

    accelerator #(.LIMB_W(64)) dut (
        .clk(clk), .resetn(resetn), .start(start), .din(din),
        .dout(dout), .done(done), .busy(busy)
    );
    accelerator #(.LIMB_W(32)) dut32 (
        .clk(clk), .resetn(resetn), .start(start_s), .din(din_s),
        .dout(dout32), .done(done32), .busy(busy32)
    );
    accelerator #(.LIMB_W(512)) dut512 (
        .clk(clk), .resetn(resetn), .start(start_s), .din(din_s),
        .dout(dout512), .done(done512), .busy(busy512)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [512:0] exp;
        int           t;
    } exp_t;

    typedef struct {
        logic [511:0] a;
        logic [511:0] b;
        logic [512:0] exp;
    } vec_t;

    exp_t         sb64[$], sb32[$], sb512[$];
    vec_t         vecs[7];
    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    logic [512:0] last64 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [512:0] act, input logic [512:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(input string nm, input logic [1023:0] d, input exp_t e, input int lat);
        chk({nm, "_sum"}, d[512:0], e.exp);
        chk({nm, "_hi"}, {2'b0, d[1023:513]}, '0);
        chk({nm, "_lat"}, cyc - e.t, lat);
    endtask

    task automatic spurious(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got done with no accepted start pending, expected none", nm);
    endtask

    // Completion monitors. A done with an empty queue is an error in itself.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && done) begin
            if (sb64.size() == 0) spurious("done64");
            else begin
                e = sb64.pop_front();
                mon("r64", dout, e, 8);
                last64 = e.exp;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn && done32) begin
            if (sb32.size() == 0) spurious("done32");
            else begin
                e = sb32.pop_front();
                mon("r32", dout32, e, 16);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn && done512) begin
            if (sb512.size() == 0) spurious("done512");
            else begin
                e = sb512.pop_front();
                mon("r512", dout512, e, 1);
            end
        end
    end

    // Waits a bounded number of negedges for done on the 64-bit instance.
    task automatic wait_done64(input string nm);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk({nm, "_timeout"}, got, 1);
    endtask

    // Full operation on the 64-bit instance. It checks that dout still holds
    // the previous result while running, the busy cycle count, and that busy is low with done.
    task automatic run_op(input string nm, input logic [511:0] a, input logic [511:0] b,
                          input logic [512:0] exp);
        int bc;
        bit got = 0;
        din   = {a, b};
        start = 1'b1;
        sb64.push_back('{exp: exp, t: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_held"}, dout[512:0], last64);
        bc = int'(busy);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else bc += int'(busy);
        end
        chk({nm, "_timeout"}, got, 1);
        chk({nm, "_busycyc"}, bc, 8);
        chk({nm, "_busydone"}, busy, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [511:0] ra, rb;
        bit           got;

        vecs[0] = '{a: 512'd1, b: 512'd1, exp: 513'd2};
        vecs[1] = '{a: {448'h0, 64'hFFFF_FFFF_FFFF_FFFF}, b: 512'd1,
                    exp: {448'h0, 1'b1, 64'h0}};
        vecs[2] = '{a: {512{1'b1}}, b: 512'd1, exp: {1'b1, 512'h0}};
        vecs[3] = '{a: {512{1'b1}}, b: {512{1'b1}}, exp: {1'b1, {511{1'b1}}, 1'b0}};
        vecs[4] = '{a: 512'd0, b: 512'd0, exp: 513'd0};
        vecs[5] = '{a: {128{4'h5}}, b: {128{4'hA}}, exp: {1'b0, {512{1'b1}}}};
        vecs[6] = '{a: {1'b1, 511'h0}, b: {1'b1, 511'h0}, exp: {1'b1, 512'h0}};

        resetn  = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        din     = '0;
        din_s   = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout[512:0], 0);
        chk("rst_dout_hi", {2'b0, dout[1023:513]}, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed vectors covering carry ripple and boundary cases.
        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

        // A start issued during RUN is ignored, and a start issued in the DONE cycle is accepted.
        din   = {vecs[3].a, vecs[3].b};
        start = 1'b1;
        sb64.push_back('{exp: vecs[3].exp, t: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        din   = {vecs[0].a, vecs[0].b};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din   = {1024{1'b1}};
        wait_done64("ignore");
        din   = {vecs[1].a, vecs[1].b};
        start = 1'b1;
        sb64.push_back('{exp: vecs[1].exp, t: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("indone_busy", busy, 1);
        chk("indone_drop", done, 0);
        wait_done64("indone");
        @(negedge clk);

        // Reset in the middle of an operation: outputs clear immediately and no done follows.
        din   = {vecs[5].a, vecs[5].b};
        start = 1'b1;
        sb64.push_back('{exp: vecs[5].exp, t: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("abort_dout", dout[512:0], 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        sb64.delete();
        last64 = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_quiet", sb64.size(), 0);
        run_op("post_rst", vecs[2].a, vecs[2].b, vecs[2].exp);

        // Random sweep on the 32-bit and 512-bit limb instances.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 16; k++) begin
                ra[k*32 +: 32] = $urandom();
                rb[k*32 +: 32] = $urandom();
            end
            din_s   = {ra, rb};
            start_s = 1'b1;
            sb32.push_back('{exp: {1'b0, ra} + {1'b0, rb}, t: cyc + 1});
            sb512.push_back('{exp: {1'b0, ra} + {1'b0, rb}, t: cyc + 1});
            @(negedge clk);
            start_s = 1'b0;
            din_s   = ~din_s;
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (done32) got = 1;
            end
            if (!got) chk("sweep_timeout", got, 1);
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("drain64", sb64.size(), 0);
        chk("drain32", sb32.size(), 0);
        chk("drain512", sb512.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
